// File: rtl/avr_tick_sched.sv
// avr_tick_sched: instruction-tick scheduler for NCORES AVR cores.
// Each core free-runs on its own divider or single-steps while halted.
// Ticks are handed out one per clk by a round-robin arbiter over the pending bits.
// Build option: define AVR_TICK_SCHED_OVR_CNT_EN to add 8-bit saturating
// per-core overrun counters. Without it ovr_cnt reads 0 and ovr_clr is ignored.
//
// Per-core FSM
//   state | meaning
//   HALT  | core stopped; waits for run (free-run) or step_req (one tick)
//   RUN   | divider counts down; expiry raises pending and reloads
//   STEP  | one tick pending; leaves to HALT when that tick is granted
module avr_tick_sched #(
    parameter int NCORES = 4,
    parameter int DIVW   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCORES*DIVW-1:0]   div_cfg,
    input  logic [NCORES-1:0]        run,
    input  logic [NCORES-1:0]        step_req,
    input  logic [NCORES-1:0]        ovr_clr,
    output logic [NCORES-1:0]        tick,
    output logic [NCORES-1:0]        step_ack,
    output logic [NCORES*8-1:0]      ovr_cnt
);

    localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_e;

    state_e            st_q   [NCORES];
    state_e            st_d   [NCORES];
    logic [DIVW-1:0]   cnt_q  [NCORES];
    logic [DIVW-1:0]   cnt_d  [NCORES];
    logic [NCORES-1:0] pend_q, pend_d;
    logic [NCORES-1:0] gnt;
    logic [NCORES-1:0] ovr_evt;
    logic [NCORES-1:0] tick_q, ack_q, ack_d;
    logic [PW-1:0]     rr_q, rr_d;

    // Round-robin grant: first pending core after the last granted one, wrapping.
    always_comb begin
        int   idx;
        logic found;
        gnt   = '0;
        rr_d  = rr_q;
        idx   = 0;
        found = 1'b0;
        for (int k = 1; k <= NCORES; k++) begin
            idx = (int'(rr_q) + k) % NCORES;
            if (!found && pend_q[idx]) begin
                gnt[idx] = 1'b1;
                rr_d     = PW'(idx);
                found    = 1'b1;
            end
        end
    end

    // Per-core next state, divider, pending bit, step acknowledge and overrun events.
    always_comb begin
        for (int i = 0; i < NCORES; i++) begin
            st_d[i]    = st_q[i];
            cnt_d[i]   = cnt_q[i];
            pend_d[i]  = pend_q[i] & ~gnt[i];
            ovr_evt[i] = 1'b0;
            ack_d[i]   = 1'b0;
            case (st_q[i])
                HALT: begin
                    if (run[i]) begin
                        st_d[i]  = RUN;
                        cnt_d[i] = div_cfg[i*DIVW +: DIVW];
                    end else if (step_req[i]) begin
                        st_d[i]   = STEP;
                        pend_d[i] = 1'b1;
                    end
                end
                RUN: begin
                    if (!run[i]) begin
                        // Stopping wins over a same-cycle expiry; a waiting tick is dropped.
                        st_d[i]   = HALT;
                        pend_d[i] = 1'b0;
                    end else if (cnt_q[i] == '0) begin
                        cnt_d[i]   = div_cfg[i*DIVW +: DIVW];
                        pend_d[i]  = 1'b1;
                        // Re-arming a pending bit that is being granted now is not an overrun.
                        ovr_evt[i] = pend_q[i] & ~gnt[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] - DIVW'(1);
                    end
                end
                STEP: begin
                    if (gnt[i]) begin
                        st_d[i]  = HALT;
                        ack_d[i] = 1'b1;
                    end
                end
                default: st_d[i] = HALT;
            endcase
        end
    end

    // State, counters, pending bits, arbiter pointer and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCORES; i++) begin
                st_q[i]  <= HALT;
                cnt_q[i] <= '0;
            end
            pend_q <= '0;
            rr_q   <= PW'(NCORES - 1);
            tick_q <= '0;
            ack_q  <= '0;
        end else begin
            for (int i = 0; i < NCORES; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            pend_q <= pend_d;
            rr_q   <= rr_d;
            tick_q <= gnt;
            ack_q  <= ack_d;
        end
    end

    assign tick     = tick_q;
    assign step_ack = ack_q;

`ifdef AVR_TICK_SCHED_OVR_CNT_EN
    logic [7:0] ovr_q [NCORES];

    // Saturating overrun counters; a clear coinciding with an overrun leaves 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCORES; i++) ovr_q[i] <= '0;
        end else begin
            for (int i = 0; i < NCORES; i++) begin
                if (ovr_clr[i]) begin
                    ovr_q[i] <= {7'd0, ovr_evt[i]};
                end else if (ovr_evt[i] && ovr_q[i] != 8'hFF) begin
                    ovr_q[i] <= ovr_q[i] + 8'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NCORES; g++) begin : g_ovr
        assign ovr_cnt[g*8 +: 8] = ovr_q[g];
    end
`else
    logic unused_ovr;
    assign unused_ovr = ^{ovr_clr, ovr_evt};
    assign ovr_cnt    = '0;
`endif

endmodule
